// File: rtl/display_pkg.sv
// Shared constants for the seven-segment frame capture: segment codes (abcdefg, active-low),
// FSM states and the default stability requirement.
package display_pkg;

  localparam int unsigned STABLE_CYCLES_DEF = 4;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHold
  } state_e;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational decode of one active-low segment pattern into a hex nibble plus
// blank (all segments dark) and err (unrecognised pattern) flags.
module seg7_to_hex
  import display_pkg::*;
(
  input  logic [6:0] seven,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       err
);

  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    err    = 1'b0;
    case (seven)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_BLANK: blank  = 1'b1;
      default:   err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/display_hex_bin.sv
// Snoops a multiplexed 4-digit seven-segment bus, debounces each digit strobe and
// publishes a complete decoded frame once all four positions have been captured.
module display_hex_bin
  import display_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seven,
  input  logic [3:0]  anode,
  output logic [15:0] value,
  output logic [3:0]  blank,
  output logic [3:0]  digit_err,
  output logic        frame_valid
);

  localparam logic [7:0] CntLast = 8'(STABLE_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [3:0]  anode_q;
  logic [6:0]  seven_q;
  logic [3:0]  mask_q;
  logic [15:0] dig_q;
  logic [3:0]  dig_blank_q;
  logic [3:0]  dig_err_q;

  logic        sample_valid;
  logic [1:0]  sample_idx;
  logic        same_sample;
  logic        capture;
  logic        frame_done;
  logic [3:0]  cap_mask;
  logic [3:0]  dec_nibble;
  logic        dec_blank;
  logic        dec_err;

  seg7_to_hex u_dec (
    .seven  (seven),
    .nibble (dec_nibble),
    .blank  (dec_blank),
    .err    (dec_err)
  );

  // Exactly one low strobe is a sample; anything else is treated as idle.
  always_comb begin
    sample_valid = 1'b1;
    sample_idx   = 2'd0;
    case (anode)
      4'b1110: sample_idx = 2'd0;
      4'b1101: sample_idx = 2'd1;
      4'b1011: sample_idx = 2'd2;
      4'b0111: sample_idx = 2'd3;
      default: sample_valid = 1'b0;
    endcase
  end

  always_comb begin
    same_sample = sample_valid && (anode == anode_q) && (seven == seven_q);
    capture     = (state_q == StSettle) && same_sample && (cnt_q == CntLast);
    frame_done  = (mask_q == 4'hF);
    cap_mask    = capture ? (4'b0001 << sample_idx) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      anode_q     <= 4'hF;
      seven_q     <= SEG_BLANK;
      mask_q      <= 4'h0;
      dig_q       <= 16'h0000;
      dig_blank_q <= 4'h0;
      dig_err_q   <= 4'h0;
      value       <= 16'h0000;
      blank       <= 4'hF;
      digit_err   <= 4'h0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= frame_done;
      if (frame_done) begin
        value     <= dig_q;
        blank     <= dig_blank_q;
        digit_err <= dig_err_q;
      end
      // A capture landing on the completion edge belongs to the next frame.
      mask_q <= (frame_done ? 4'h0 : mask_q) | cap_mask;
      if (capture) begin
        dig_q[{sample_idx, 2'b00} +: 4] <= dec_nibble;
        dig_blank_q[sample_idx]         <= dec_blank;
        dig_err_q[sample_idx]           <= dec_err;
      end

      case (state_q)
        StIdle: begin
          if (sample_valid) begin
            state_q <= StSettle;
            cnt_q   <= 8'd1;
            anode_q <= anode;
            seven_q <= seven;
          end
        end
        StSettle: begin
          if (!sample_valid) begin
            state_q <= StIdle;
          end else if (same_sample) begin
            cnt_q <= cnt_q + 8'd1;
            if (capture) state_q <= StHold;
          end else begin
            cnt_q   <= 8'd1;
            anode_q <= anode;
            seven_q <= seven;
          end
        end
        StHold: begin
          if (!sample_valid) begin
            state_q <= StIdle;
          end else if (!same_sample) begin
            state_q <= StSettle;
            cnt_q   <= 8'd1;
            anode_q <= anode;
            seven_q <= seven;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/display_hex_bin.md
DISPLAY_HEX_BIN -- requirements
Module: display_hex_bin

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, meaning the number of consecutive identical samples required before a digit is accepted; legal range 2..255.
REQ-002 clk  input  1  sole clock; all logic updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 seven  input  7  segment lines a b c d e f g (bit 6 = a), active-low.
REQ-005 anode  input  4  digit strobes, active-low one-hot (bit 0 = least significant digit).
REQ-006 value  output  16  last complete decoded frame, digit i in bits [4i+3:4i].
REQ-007 blank  output  4  per-digit flag: the digit was dark (all segments off) in the last frame.
REQ-008 digit_err  output  4  per-digit flag: the segment pattern was not a legal code in the last frame.
REQ-009 frame_valid  output  1  one-cycle pulse indicating that value, blank and digit_err were updated.

Function
REQ-010 The block SHALL decode active-low patterns: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9, 0001000=A, 1100000=B, 0110001=C, 1000010=D.
REQ-011 Pattern 1111111 SHALL decode to nibble 0 with its blank flag set; every other pattern SHALL decode to nibble 0 with its error flag set.
REQ-012 A sample is valid only when anode has exactly one bit low; all-high or multi-low anode SHALL be treated as idle.
REQ-013 FSM states: IDLE, SETTLE, HOLD.
REQ-014 IDLE -> SETTLE on a valid sample, with the stability counter loaded to 1 and the anode/seven values latched.
REQ-015 In SETTLE, an identical sample SHALL increment the counter; a differing valid sample SHALL reload the latch with counter = 1; an idle sample SHALL return the FSM to IDLE.
REQ-016 When the counter reaches STABLE_CYCLES, the block SHALL store the decoded digit, blank and error for that anode position, set its bit in the captured mask, and enter HOLD.
REQ-017 In HOLD, an identical sample SHALL cause no action; a differing valid sample SHALL go to SETTLE (counter = 1); an idle sample SHALL go to IDLE.
REQ-018 Each anode activation SHALL be captured at most once; a recapture of a position before frame completion SHALL overwrite that position's stored digit.
REQ-019 On the edge after the mask becomes 4'b1111, the block SHALL copy the stored digits and flags to value, blank and digit_err, assert frame_valid for exactly one cycle, and clear the mask.
REQ-020 If a capture sets a mask bit in the same cycle as frame completion, that capture SHALL count toward the next frame.
REQ-021 Outputs SHALL hold their values between frames.
REQ-022 Minimum latency from the first sample of the final digit to frame_valid SHALL be STABLE_CYCLES+1 cycles.

Reset
REQ-023 While rst is high at a rising edge: FSM to IDLE, counter, mask and stored digits to 0; value = 16'h0000, blank = 4'hF, digit_err = 4'h0, frame_valid = 0.
REQ-024 Reset mid-frame SHALL discard partially captured digits; the first frame_valid after reset SHALL require all four positions to be captured anew.

Structure
REQ-025 Shared package display_pkg SHALL hold the segment code constants (including SEG_BLANK = 7'b1111111), the FSM state enum, and the STABLE_CYCLES default.
REQ-026 Combinational sub-module seg7_to_hex SHALL map seven to {nibble, blank, err}; all sequencing SHALL remain in display_hex_bin.

Verification
REQ-027 Reset check: after reset, value=0000, blank=F, digit_err=0, frame_valid=0; no pulse while anode=1111 for 100 cycles.
REQ-028 Clean scan: scan digits 3,2,1,0 showing C,0,D,E-blank, 8 cycles each -> one frame_valid with value=C0D0, blank=0001, digit_err=0.
REQ-029 Glitch rejection: hold digit 0 for STABLE_CYCLES-1 cycles, then switch to digit 1 -> digit 0 is not captured and no frame_valid until digit 0 is rescanned stable.
REQ-030 Illegal code: digit 2 shows 0110000 (E) stably within an otherwise legal scan -> digit_err=0100, value nibble 2=0.
REQ-031 Multi-low anode: anode=1100 for 20 cycles in mid-scan -> no capture, FSM returns to IDLE, frame completes normally once scanning resumes.
REQ-032 Reset mid-frame: assert rst after three digits are captured, then scan one full frame -> exactly one frame_valid, carrying only post-reset data.
